// File: rtl/axi_stream_tp_check.sv
// AXI4-Stream video sink: checks SOF/EOL placement and optional {line,pixel} test-pattern data against a programmed geometry.
// Status registers one cycle after the beat; tready low in IDLE, and one cycle per STALL_PERIOD when STALL_EN=1.
module axi_stream_tp_check #(
  parameter int STALL_EN     = 0,
  parameter int STALL_PERIOD = 8,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           s_tdata_i,
  input  logic                 s_tvalid_i,
  output logic                 s_tready_o,
  input  logic                 s_tuser_i,
  input  logic                 s_tlast_i,
  input  logic                 chk_enable_i,
  input  logic [10:0]          chk_width_i,
  input  logic [10:0]          chk_height_i,
  input  logic                 chk_pattern_en_i,
  input  logic                 err_clr_i,
  output logic [15:0]          frame_cnt_o,
  output logic [10:0]          last_width_o,
  output logic [10:0]          last_height_o,
  output logic                 err_sof_o,
  output logic                 err_eol_o,
  output logic                 err_data_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  localparam logic [10:0] PX_MAX     = 11'h7FF;
  localparam logic [7:0]  STALL_LAST = 8'(STALL_PERIOD - 1);

  state_t               state_q, state_d;
  logic                 en_prev_q, en_prev_d;
  logic [10:0]          width_q, width_d;
  logic [10:0]          height_q, height_d;
  logic                 pat_en_q, pat_en_d;
  logic [10:0]          px_q, px_d;
  logic [10:0]          ln_q, ln_d;
  logic [7:0]           stall_q, stall_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [10:0]          last_width_q, last_width_d;
  logic [10:0]          last_height_q, last_height_d;
  logic                 err_sof_q, err_sof_d;
  logic                 err_eol_q, err_eol_d;
  logic                 err_data_q, err_data_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 en_rise;
  logic                 stall_now;
  logic                 beat;
  logic                 take;
  logic [10:0]          px_e;
  logic [10:0]          ln_e;
  logic                 sof_ev;
  logic                 eol_early_ev;
  logic                 eol_miss_ev;
  logic                 data_ev;
  logic                 line_end;
  logic                 frame_end;
  logic [2:0]           n_err;
  logic [ERR_CNT_W:0]   err_sum;

  // The stall counter free-runs in every state so the ready pattern is independent of traffic.
  always_comb begin
    stall_d   = (stall_q == STALL_LAST) ? 8'd0 : stall_q + 8'd1;
    stall_now = (STALL_EN != 0) && (stall_q == STALL_LAST);
  end

  assign s_tready_o = (state_q != IDLE) && chk_enable_i && !stall_now;

  always_comb begin
    en_prev_d = chk_enable_i;
    en_rise   = chk_enable_i & ~en_prev_q;
    beat      = s_tvalid_i & s_tready_o;
    // In WAIT_SOF only a tuser beat is consumed; everything else is silently dropped.
    take      = beat && ((state_q == ACTIVE) || s_tuser_i);
    // A tuser beat is always treated as pixel (0,0), which also resyncs a broken frame.
    px_e      = s_tuser_i ? 11'd0 : px_q;
    ln_e      = s_tuser_i ? 11'd0 : ln_q;

    sof_ev       = take && (state_q == ACTIVE) && s_tuser_i && ((px_q != 11'd0) || (ln_q != 11'd0));
    line_end     = take && s_tlast_i;
    frame_end    = line_end && (ln_e == height_q - 11'd1);
    eol_early_ev = line_end && (px_e != width_q - 11'd1);
    eol_miss_ev  = take && !s_tlast_i && (px_e == width_q - 11'd1);
    data_ev      = take && pat_en_q && (s_tdata_i != {ln_e[3:0], px_e[3:0]});

    n_err   = 3'(sof_ev) + 3'(eol_early_ev) + 3'(eol_miss_ev) + 3'(data_ev);
    err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(n_err);
  end

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    pat_en_d      = pat_en_q;
    px_d          = px_q;
    ln_d          = ln_q;
    frame_cnt_d   = frame_cnt_q;
    last_width_d  = last_width_q;
    last_height_d = last_height_q;

    if (en_rise) begin
      width_d  = chk_width_i;
      height_d = chk_height_i;
      pat_en_d = chk_pattern_en_i;
    end

    case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d = WAIT_SOF;
        end
      end
      default: begin
        if (take) begin
          if (line_end) begin
            last_width_d = (px_e == PX_MAX) ? PX_MAX : px_e + 11'd1;
            px_d         = 11'd0;
            if (frame_end) begin
              ln_d          = 11'd0;
              frame_cnt_d   = frame_cnt_q + 16'd1;
              last_height_d = ln_e + 11'd1;
              state_d       = WAIT_SOF;
            end else begin
              ln_d    = ln_e + 11'd1;
              state_d = ACTIVE;
            end
          end else begin
            px_d    = (px_e == PX_MAX) ? PX_MAX : px_e + 11'd1;
            ln_d    = ln_e;
            state_d = ACTIVE;
          end
        end
      end
    endcase

    if (!chk_enable_i) begin
      state_d = IDLE;
    end
  end

  // A clear coinciding with a new error keeps the new error.
  always_comb begin
    if (err_clr_i) begin
      err_sof_d  = sof_ev;
      err_eol_d  = eol_early_ev | eol_miss_ev;
      err_data_d = data_ev;
      err_cnt_d  = ERR_CNT_W'(n_err);
    end else begin
      err_sof_d  = err_sof_q | sof_ev;
      err_eol_d  = err_eol_q | eol_early_ev | eol_miss_ev;
      err_data_d = err_data_q | data_ev;
      err_cnt_d  = err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      en_prev_q     <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      pat_en_q      <= 1'b0;
      px_q          <= '0;
      ln_q          <= '0;
      stall_q       <= '0;
      frame_cnt_q   <= '0;
      last_width_q  <= '0;
      last_height_q <= '0;
      err_sof_q     <= 1'b0;
      err_eol_q     <= 1'b0;
      err_data_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      en_prev_q     <= en_prev_d;
      width_q       <= width_d;
      height_q      <= height_d;
      pat_en_q      <= pat_en_d;
      px_q          <= px_d;
      ln_q          <= ln_d;
      stall_q       <= stall_d;
      frame_cnt_q   <= frame_cnt_d;
      last_width_q  <= last_width_d;
      last_height_q <= last_height_d;
      err_sof_q     <= err_sof_d;
      err_eol_q     <= err_eol_d;
      err_data_q    <= err_data_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign frame_cnt_o   = frame_cnt_q;
  assign last_width_o  = last_width_q;
  assign last_height_o = last_height_q;
  assign err_sof_o     = err_sof_q;
  assign err_eol_o     = err_eol_q;
  assign err_data_o    = err_data_q;
  assign err_cnt_o     = err_cnt_q;

endmodule
